// File: rtl/sum_checker_pkg.sv
// Shared types and default sizing for the add-constant result checker.
package sum_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_OFFSET = 3;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sum_result_checker.sv
// Recomputes in + OFFSET for each sample pair from the add-constant stage,
// counts checked/failing beats and captures the first mismatch.
//
// state | meaning
// IDLE  | after reset, not accepting samples
// RUN   | accepting and checking sample pairs
// DRAIN | no longer accepting, pipeline still holds beats
// DONE  | pipeline empty, counters and capture final
module sum_result_checker
  import sum_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OFFSET = DEF_OFFSET,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] s_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] n_checked,
  output logic [CNT_W-1:0] n_errors,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_in,
  output logic [WIDTH-1:0] err_got,
  output logic [WIDTH-1:0] err_exp
);

  localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

  state_t           state;
  logic             go;
  logic             accept;
  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] exp1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] exp2;
  logic             mis2;

  assign s_ready = (state == RUN);
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);
  assign pass    = done && (n_errors == '0);
  assign accept  = s_valid && s_ready;
  assign go      = start && ((state == IDLE) || (state == DONE));
  assign exp1    = in1 + OFF_W;

  // Exit decisions look at next-cycle occupancy (v1 <= accept, v2 <= v1),
  // so the last beat is counted on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (finish) state <= (accept || v1) ? DRAIN : DONE;
        DRAIN:   if (!v1) state <= DONE;
        DONE:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      in1  <= '0;
      out1 <= '0;
      in2  <= '0;
      out2 <= '0;
      exp2 <= '0;
      mis2 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        in1  <= s_in;
        out1 <= s_out;
      end
      if (v1) begin
        in2  <= in1;
        out2 <= out1;
        exp2 <= exp1;
        mis2 <= (out1 != exp1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || go) begin
      err_valid <= 1'b0;
      err_in    <= '0;
      err_got   <= '0;
      err_exp   <= '0;
    end else if (v2 && mis2 && !err_valid) begin
      err_valid <= 1'b1;
      err_in    <= in2;
      err_got   <= out2;
      err_exp   <= exp2;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_checked (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .inc   (v2),
    .count (n_checked)
  );

  sat_counter #(.CNT_W(CNT_W)) u_errors (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .inc   (v2 && mis2),
    .count (n_errors)
  );

endmodule

// File: tb/tb_sum_result_checker.sv
// Directed bench for sum_result_checker; a 3-bit-counter copy shares the stimulus.
module tb_sum_result_checker;

  logic         clk = 1'b0;
  logic         rst, start, finish, s_valid;
  logic [127:0] s_in, s_out;

  logic         s_ready, busy, done, pass, err_valid;
  logic [31:0]  n_checked, n_errors;
  logic [127:0] err_in, err_got, err_exp;

  logic         s3_ready, s3_busy, s3_done, s3_pass, s3_err_valid;
  logic [2:0]   s3_n_checked, s3_n_errors;
  logic [127:0] s3_err_in, s3_err_got, s3_err_exp;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] ALL1 = {128{1'b1}};

  always #5 clk = ~clk;

  sum_result_checker dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_out(s_out),
    .busy(busy), .done(done), .pass(pass),
    .n_checked(n_checked), .n_errors(n_errors),
    .err_valid(err_valid), .err_in(err_in), .err_got(err_got), .err_exp(err_exp)
  );

  sum_result_checker #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .s_valid(s_valid), .s_ready(s3_ready), .s_in(s_in), .s_out(s_out),
    .busy(s3_busy), .done(s3_done), .pass(s3_pass),
    .n_checked(s3_n_checked), .n_errors(s3_n_errors),
    .err_valid(s3_err_valid), .err_in(s3_err_in), .err_got(s3_err_got),
    .err_exp(s3_err_exp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] a, input logic [127:0] b);
    s_valid = 1'b1;
    s_in    = a;
    s_out   = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, pass, s_ready, err_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, s_ready, err_valid});
    end
    checks++;
    if (n_checked !== 32'd0 || n_errors !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", n_checked, n_errors);
    end
    checks++;
    if (err_in !== 128'd0 || err_got !== 128'd0 || err_exp !== 128'd0) begin
      failures++;
      $display("FAIL reset_err got=%0h/%0h/%0h exp=0", err_in, err_got, err_exp);
    end
    s_valid = 1'b1;
    s_in    = 128'd5;
    s_out   = 128'd0;
    repeat (5) tick();
    s_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (n_checked !== 32'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore got=%0d ready=%b exp=0 ready=0", n_checked, s_ready);
    end
  endtask

  task automatic test_clean();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL clean_enter got=%b%b exp=11", busy, s_ready);
    end
    drive(128'd0, 128'd3);
    drive(128'd1, 128'd4);
    drive(128'd100, 128'd103);
    drive(ALL1 - 128'd2, 128'd0);
    drive(ALL1, 128'd2);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clean_done_timeout got=0 exp=1");
    end
    checks++;
    if (pass !== 1'b1 || n_checked !== 32'd5 || n_errors !== 32'd0 || err_valid !== 1'b0) begin
      failures++;
      $display("FAIL clean_result got pass=%b chk=%0d err=%0d ev=%b exp pass=1 chk=5 err=0 ev=0",
               pass, n_checked, n_errors, err_valid);
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (n_checked !== 32'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear got chk=%0d busy=%b exp chk=0 busy=1", n_checked, busy);
    end
    drive(128'd10, 128'd13);
    drive(128'd20, 128'd22);
    drive(128'd30, 128'd99);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || pass !== 1'b0) begin
      failures++;
      $display("FAIL mis_done got done=%b pass=%b exp done=1 pass=0", done, pass);
    end
    checks++;
    if (n_checked !== 32'd3 || n_errors !== 32'd2) begin
      failures++;
      $display("FAIL mis_counts got=%0d/%0d exp=3/2", n_checked, n_errors);
    end
    checks++;
    if (err_valid !== 1'b1 || err_in !== 128'd20 || err_got !== 128'd22 || err_exp !== 128'd23) begin
      failures++;
      $display("FAIL mis_capture got ev=%b in=%0d got=%0d exp=%0d exp ev=1 in=20 got=22 exp=23",
               err_valid, err_in, err_got, err_exp);
    end
  endtask

  task automatic test_latency();
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_in    = 128'd7;
    s_out   = 128'd10;
    finish  = 1'b1;
    tick();
    s_valid = 1'b0;
    finish  = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || n_checked !== 32'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL lat_edge1 got busy=%b done=%b chk=%0d rdy=%b exp 1 0 0 0", busy, done, n_checked, s_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || n_checked !== 32'd0) begin
      failures++;
      $display("FAIL lat_edge2 got busy=%b chk=%0d exp busy=1 chk=0", busy, n_checked);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || n_checked !== 32'd1 || pass !== 1'b1) begin
      failures++;
      $display("FAIL lat_edge3 got busy=%b done=%b chk=%0d pass=%b exp 0 1 1 1", busy, done, n_checked, pass);
    end
  endtask

  task automatic test_restart();
    bit ok;
    start  = 1'b1;
    finish = 1'b1;
    tick();
    start  = 1'b0;
    finish = 1'b0;
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0 || n_checked !== 32'd0) begin
      failures++;
      $display("FAIL start_finish_done got busy=%b rdy=%b done=%b chk=%0d exp 1 1 0 0",
               busy, s_ready, done, n_checked);
    end
    drive(128'd1, 128'd4);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || n_checked !== 32'd1) begin
      failures++;
      $display("FAIL start_in_run got busy=%b rdy=%b chk=%0d exp 1 1 1", busy, s_ready, n_checked);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL restart_done_timeout got=0 exp=1");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(128'd1, 128'd4);
    drive(128'd2, 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (n_checked !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got chk=%0d busy=%b done=%b rdy=%b exp 0 0 0 0", n_checked, busy, done, s_ready);
    end
    repeat (3) tick();
    checks++;
    if (n_checked !== 32'd0) begin
      failures++;
      $display("FAIL rst_flush got=%0d exp=0", n_checked);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(128'd3, 128'd6);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || n_checked !== 32'd1 || n_errors !== 32'd0) begin
      failures++;
      $display("FAIL rst_rerun got done=%b chk=%0d err=%0d exp 1 1 0", done, n_checked, n_errors);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) drive(128'(i), 128'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || s3_done !== 1'b1) begin
      failures++;
      $display("FAIL sat_done got=%b/%b exp=1/1", done, s3_done);
    end
    checks++;
    if (s3_n_errors !== 3'd7 || s3_n_checked !== 3'd7) begin
      failures++;
      $display("FAIL sat_counts got=%0d/%0d exp=7/7", s3_n_checked, s3_n_errors);
    end
    checks++;
    if (n_checked !== 32'd9 || n_errors !== 32'd9) begin
      failures++;
      $display("FAIL wide_counts got=%0d/%0d exp=9/9", n_checked, n_errors);
    end
    checks++;
    if (s3_err_in !== 128'd0 || s3_err_exp !== 128'd3 || s3_pass !== 1'b0) begin
      failures++;
      $display("FAIL sat_capture got in=%0d exp=%0d pass=%b exp in=0 exp=3 pass=0",
               s3_err_in, s3_err_exp, s3_pass);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; s_valid = 1'b0;
    s_in = '0; s_out = '0;
    #1;
    test_reset();
    test_clean();
    test_mismatch();
    test_latency();
    test_restart();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
